// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 720p raster timing constants, region boundaries and region type
package vga_pkg;

    localparam int H_ACTIVE = 1280;
    localparam int H_FP     = 110;
    localparam int H_SYNC   = 40;
    localparam int H_BP     = 220;
    localparam int V_ACTIVE = 720;
    localparam int V_FP     = 5;
    localparam int V_SYNC   = 5;
    localparam int V_BP     = 20;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_FP_START   = H_ACTIVE;
    localparam int H_SYNC_START = H_FP_START + H_FP;
    localparam int H_BP_START   = H_SYNC_START + H_SYNC;
    localparam int V_FP_START   = V_ACTIVE;
    localparam int V_SYNC_START = V_FP_START + V_FP;
    localparam int V_BP_START   = V_SYNC_START + V_SYNC;

    localparam int CNT_W = 11;

    typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} vga_region_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - control inputs and raster outputs of the timing generator
interface vga_timing_gen_if;

    logic        enable;
    logic        resync;
    logic [31:0] H_pos;
    logic [31:0] V_pos;
    logic        valid_video;
    logic        hblank;
    logic        vblank;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        input  enable, resync,
        output H_pos, V_pos, valid_video, hblank, vblank, line_start, frame_start, frame_cnt
    );

    modport slave (
        output enable, resync,
        input  H_pos, V_pos, valid_video, hblank, vblank, line_start, frame_start, frame_cnt
    );

endinterface

// File: rtl/vtg_axis_counter.sv
// rtl/vtg_axis_counter.sv - one raster axis: position counter plus ACTIVE/FP/SYNC/BP region FSM
module vtg_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE_LEN = H_ACTIVE,
    parameter int FP_LEN     = H_FP,
    parameter int SYNC_LEN   = H_SYNC,
    parameter int BP_LEN     = H_BP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output vga_region_t      region,
    output vga_region_t      region_nxt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE_LEN);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE_LEN + FP_LEN);
    localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN - 1);

    logic [CNT_W-1:0] count_q, count_d;
    vga_region_t      region_q, region_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            region_q <= ACTIVE;
        end else begin
            count_q  <= count_d;
            region_q <= region_d;
        end
    end

    // Region changes are decided on the next count so the region flop lines up with the count flop.
    always_comb begin
        count_d  = count_q;
        region_d = region_q;
        wrap     = 1'b0;
        if (clear) begin
            count_d  = '0;
            region_d = ACTIVE;
        end else if (step) begin
            if (count_q == LAST) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            case (region_q)
                ACTIVE:  if (count_d == FP_START)   region_d = FP;
                FP:      if (count_d == SYNC_START) region_d = SYNC;
                SYNC:    if (count_d == BP_START)   region_d = BP;
                BP:      if (wrap)                  region_d = ACTIVE;
                default: begin
                    region_d = ACTIVE;
                    count_d  = '0;
                end
            endcase
        end
    end

    assign count      = count_q;
    assign region     = region_q;
    assign region_nxt = region_d;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 720p raster timing generator top; VTG_FRAME_CNT_EN enables frame_cnt
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int IMAGE_WIDTH   = H_ACTIVE,
    parameter int HFP_WIDTH     = H_FP,
    parameter int HSYNCH_WIDTH  = H_SYNC,
    parameter int HBP_WIDTH     = H_BP,
    parameter int IMAGE_HEIGHT  = V_ACTIVE,
    parameter int VFP_HEIGHT    = V_FP,
    parameter int VSYNCH_HEIGHT = V_SYNC,
    parameter int VBP_HEIGHT    = V_BP
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  vif
);

    logic [CNT_W-1:0] h_count, v_count;
    vga_region_t      h_region, v_region, h_region_nxt, v_region_nxt;
    logic             h_wrap, v_wrap;

    logic valid_video_q, valid_video_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    vtg_axis_counter #(
        .ACTIVE_LEN (IMAGE_WIDTH),
        .FP_LEN     (HFP_WIDTH),
        .SYNC_LEN   (HSYNCH_WIDTH),
        .BP_LEN     (HBP_WIDTH)
    ) u_h_axis (
        .clk        (clk),
        .reset_n    (reset_n),
        .step       (vif.enable),
        .clear      (vif.resync),
        .count      (h_count),
        .region     (h_region),
        .region_nxt (h_region_nxt),
        .wrap       (h_wrap)
    );

    // h_wrap is already qualified by enable and suppressed by resync.
    vtg_axis_counter #(
        .ACTIVE_LEN (IMAGE_HEIGHT),
        .FP_LEN     (VFP_HEIGHT),
        .SYNC_LEN   (VSYNCH_HEIGHT),
        .BP_LEN     (VBP_HEIGHT)
    ) u_v_axis (
        .clk        (clk),
        .reset_n    (reset_n),
        .step       (h_wrap),
        .clear      (vif.resync),
        .count      (v_count),
        .region     (v_region),
        .region_nxt (v_region_nxt),
        .wrap       (v_wrap)
    );

    always_comb begin
        line_start_d  = vif.resync | h_wrap;
        frame_start_d = vif.resync | v_wrap;
        valid_video_d = valid_video_q;
        if (vif.resync || vif.enable) begin
            valid_video_d = (h_region_nxt == ACTIVE) && (v_region_nxt == ACTIVE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_video_q <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            valid_video_q <= valid_video_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VTG_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (v_wrap) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frame_cnt_q <= '0;
        else          frame_cnt_q <= frame_cnt_d;
    end

    assign vif.frame_cnt = frame_cnt_q;
`else
    assign vif.frame_cnt = 16'h0000;
`endif

    assign vif.H_pos       = 32'(h_count);
    assign vif.V_pos       = 32'(v_count);
    assign vif.hblank      = (h_region != ACTIVE);
    assign vif.vblank      = (v_region != ACTIVE);
    assign vif.valid_video = valid_video_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: full-size 720p instance plus a reduced raster for frame-level cases
module tb_vga_timing_gen;

    import vga_pkg::*;

`ifdef VTG_FRAME_CNT_EN
    localparam int FC3 = 3;
`else
    localparam int FC3 = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if big_if ();
    vga_timing_gen_if small_if ();

    vga_timing_gen u_big (
        .clk     (clk),
        .reset_n (rst_n),
        .vif     (big_if.master)
    );

    // Reduced raster: 15 x 8 positions, active window 8 x 4.
    vga_timing_gen #(
        .IMAGE_WIDTH   (8),
        .HFP_WIDTH     (2),
        .HSYNCH_WIDTH  (2),
        .HBP_WIDTH     (3),
        .IMAGE_HEIGHT  (4),
        .VFP_HEIGHT    (1),
        .VSYNCH_HEIGHT (1),
        .VBP_HEIGHT    (2)
    ) u_small (
        .clk     (clk),
        .reset_n (rst_n),
        .vif     (small_if.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int t3_en [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int t3_h  [10] = '{1648, 1648, 1649, 1649, 0, 0, 1, 1, 2, 2};
    int t3_ls [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int t3_hb [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        int e_h, e_v, e_hb, e_ls, e_vv, hb_ones, ls_ones;
        int e_pos, e_fs, fs_ones, vv_ones;
        int eh, ev, pos;

        rst_n = 1'b0;
        big_if.enable = 1'b0;   big_if.resync = 1'b0;
        small_if.enable = 1'b0; small_if.resync = 1'b0;
        repeat (2) tick();

        check("rst_h", big_if.H_pos, 0);
        check("rst_v", big_if.V_pos, 0);
        check("rst_valid", 32'(big_if.valid_video), 0);
        check("rst_hblank", 32'(big_if.hblank), 0);
        check("rst_vblank", 32'(big_if.vblank), 0);
        check("rst_ls", 32'(big_if.line_start), 0);
        check("rst_fs", 32'(big_if.frame_start), 0);
        check("rst_fc", 32'(big_if.frame_cnt), 0);

        // One full line on the 720p instance.
        rst_n = 1'b1;
        big_if.enable = 1'b1;
        e_h = 0; e_v = 0; e_hb = 0; e_ls = 0; e_vv = 0; hb_ones = 0; ls_ones = 0;
        for (int i = 1; i <= 1650; i++) begin
            tick();
            eh = (i == 1650) ? 0 : i;
            if (big_if.H_pos !== 32'(eh)) e_h++;
            if (big_if.V_pos !== ((i == 1650) ? 32'd1 : 32'd0)) e_v++;
            if (big_if.hblank !== (eh >= H_FP_START)) e_hb++;
            if (big_if.valid_video !== (eh < H_FP_START)) e_vv++;
            if (big_if.line_start !== (i == 1650)) e_ls++;
            if (big_if.hblank) hb_ones++;
            if (big_if.line_start) ls_ones++;
        end
        check("t1_h_seq", e_h, 0);
        check("t1_v_seq", e_v, 0);
        check("t1_hblank_seq", e_hb, 0);
        check("t1_valid_seq", e_vv, 0);
        check("t1_ls_seq", e_ls, 0);
        check("t1_hblank_ones", hb_ones, 370);
        check("t1_ls_ones", ls_ones, 1);
        check("t1_v_end", big_if.V_pos, 1);

        // Alternating enable across the end of line 1.
        repeat (1647) tick();
        check("t3_pre_h", big_if.H_pos, 1647);
        for (int k = 0; k < 10; k++) begin
            big_if.enable = (t3_en[k] != 0);
            tick();
            check("t3_h", big_if.H_pos, t3_h[k]);
            check("t3_ls", 32'(big_if.line_start), t3_ls[k]);
            check("t3_hblank", 32'(big_if.hblank), t3_hb[k]);
        end
        check("t3_v", big_if.V_pos, 2);

        // Resync mid-line.
        big_if.enable = 1'b1;
        repeat (498) tick();
        check("t4_pre_h", big_if.H_pos, 500);
        check("t4_pre_v", big_if.V_pos, 2);
        big_if.resync = 1'b1;
        tick();
        check("t4_h", big_if.H_pos, 0);
        check("t4_v", big_if.V_pos, 0);
        check("t4_valid", 32'(big_if.valid_video), 1);
        check("t4_ls", 32'(big_if.line_start), 1);
        check("t4_fs", 32'(big_if.frame_start), 1);
        check("t4_fc", 32'(big_if.frame_cnt), 0);
        big_if.resync = 1'b0;
        big_if.enable = 1'b0;
        tick();
        check("t4_ls_drop", 32'(big_if.line_start), 0);
        check("t4_fs_drop", 32'(big_if.frame_start), 0);
        check("t4_h_hold", big_if.H_pos, 0);
        check("t4_valid_hold", 32'(big_if.valid_video), 1);

        // Asynchronous reset mid-line, observed before the next edge.
        big_if.enable = 1'b1;
        repeat (900) tick();
        check("t5_pre_h", big_if.H_pos, 900);
        #2 rst_n = 1'b0;
        #1;
        check("t5_h", big_if.H_pos, 0);
        check("t5_v", big_if.V_pos, 0);
        check("t5_valid", 32'(big_if.valid_video), 0);
        check("t5_hblank", 32'(big_if.hblank), 0);
        check("t5_ls", 32'(big_if.line_start), 0);
        check("t5_fs", 32'(big_if.frame_start), 0);

        // Frame-level behaviour on the reduced raster.
        big_if.enable = 1'b0;
        tick();
        rst_n = 1'b1;
        small_if.enable = 1'b1;
        e_pos = 0; e_fs = 0; fs_ones = 0; vv_ones = 0;
        for (int i = 1; i <= 360; i++) begin
            tick();
            pos = i % 120;
            eh = pos % 15;
            ev = pos / 15;
            if (small_if.H_pos !== 32'(eh) || small_if.V_pos !== 32'(ev)) e_pos++;
            if (small_if.frame_start !== (pos == 0)) e_fs++;
            if (small_if.frame_start) fs_ones++;
            if (i > 120 && i <= 240 && small_if.valid_video) vv_ones++;
            if (i == 119) begin
                check("t2_last_h", small_if.H_pos, 14);
                check("t2_last_v", small_if.V_pos, 7);
                check("t2_last_hblank", 32'(small_if.hblank), 1);
                check("t2_last_vblank", 32'(small_if.vblank), 1);
            end
            if (i == 120) begin
                check("t2_wrap_h", small_if.H_pos, 0);
                check("t2_wrap_v", small_if.V_pos, 0);
                check("t2_wrap_valid", 32'(small_if.valid_video), 1);
                check("t2_wrap_vblank", 32'(small_if.vblank), 0);
                check("t2_wrap_fs", 32'(small_if.frame_start), 1);
            end
        end
        check("t2_pos_seq", e_pos, 0);
        check("t2_fs_seq", e_fs, 0);
        check("t2_fs_ones", fs_ones, 3);
        check("t2_valid_per_frame", vv_ones, 32);
        check("t6_fc", 32'(small_if.frame_cnt), FC3);

        // Resync from the last blanking position, coinciding with a natural frame wrap.
        repeat (119) tick();
        check("t4s_pre_h", small_if.H_pos, 14);
        check("t4s_pre_v", small_if.V_pos, 7);
        check("t4s_pre_valid", 32'(small_if.valid_video), 0);
        small_if.resync = 1'b1;
        tick();
        check("t4s_h", small_if.H_pos, 0);
        check("t4s_v", small_if.V_pos, 0);
        check("t4s_valid", 32'(small_if.valid_video), 1);
        check("t4s_ls", 32'(small_if.line_start), 1);
        check("t4s_fs", 32'(small_if.frame_start), 1);
        check("t4s_fc", 32'(small_if.frame_cnt), FC3);
        small_if.resync = 1'b0;
        tick();
        check("t4s_fs_drop", 32'(small_if.frame_start), 0);
        check("t4s_h_next", small_if.H_pos, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
